// File: rtl/led_breather.sv
// led_breather: tick-paced breathing LED (ramp up, hold, ramp down, hold) rendered by a free-running PWM
module led_breather #(
   parameter int PWM_BITS   = 8,
   parameter int STEP       = 1,
   parameter int HOLD_TICKS = 4,
   parameter bit ACTIVE_LOW = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                tick,
   output logic                nLED,
   output logic [PWM_BITS-1:0] brightness,
   output logic [1:0]          phase,
   output logic                cycleDone
);
   localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS:0]   MAXW      = {1'b0, MAX};
   localparam logic [PWM_BITS:0]   STEPW     = (PWM_BITS + 1)'(STEP);
   localparam int                  HW        = HOLD_TICKS > 1 ? $clog2(HOLD_TICKS) : 1;
   localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_TICKS > 0 ? HOLD_TICKS - 1 : 0);

   typedef enum logic [1:0] {RISE, HOLD_HI, FALL, HOLD_LO} phaseT;

   phaseT               state, stateNext;
   logic [PWM_BITS-1:0] brightNext;
   logic [HW-1:0]       holdCnt, holdNext;
   logic                doneNext;
   logic                tickD, tickEdge, act;
   logic [PWM_BITS-1:0] pwmCnt, duty;
   logic                ledOn;
   logic [PWM_BITS:0]   sumUp;
   logic [PWM_BITS-1:0] upSat, downSat;

   assign tickEdge = tick & ~tickD;
   assign act      = enable & tickEdge;
   // Saturating arithmetic: add one bit wider and clamp, subtract only when it cannot underflow
   assign sumUp    = {1'b0, brightness} + STEPW;
   assign upSat    = sumUp > MAXW ? MAX : sumUp[PWM_BITS-1:0];
   assign downSat  = {1'b0, brightness} > STEPW ? brightness - STEPW[PWM_BITS-1:0] : '0;
   assign phase    = state;
   assign ledOn    = (pwmCnt < duty) & enable;

   // Tick history runs every cycle so edges seen while disabled are consumed, not deferred
   always_ff @(posedge clk) begin
      if (!rst) tickD <= 1'b0;
      else      tickD <= tick;
   end

   // Breathing FSM state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= RISE;
         brightness <= '0;
         holdCnt    <= '0;
         cycleDone  <= 1'b0;
      end else begin
         state      <= stateNext;
         brightness <= brightNext;
         holdCnt    <= holdNext;
         cycleDone  <= doneNext;
      end
   end

   // Next-state logic: advances only on an enabled tick edge
   always_comb begin
      stateNext  = state;
      brightNext = brightness;
      holdNext   = holdCnt;
      doneNext   = 1'b0;
      if (act) begin
         case (state)
            RISE: begin
               brightNext = upSat;
               if (upSat == MAX) begin
                  holdNext = '0;
                  if (HOLD_TICKS == 0) stateNext = FALL;
                  else                 stateNext = HOLD_HI;
               end
            end
            HOLD_HI, HOLD_LO: begin
               if (holdCnt == HOLD_LAST) begin
                  holdNext = '0;
                  doneNext = (state == HOLD_LO);
                  if (state == HOLD_HI) stateNext = FALL;
                  else                  stateNext = RISE;
               end else begin
                  holdNext = holdCnt + 1'b1;
               end
            end
            FALL: begin
               brightNext = downSat;
               if (downSat == '0) begin
                  holdNext = '0;
                  doneNext = (HOLD_TICKS == 0);
                  if (HOLD_TICKS == 0) stateNext = RISE;
                  else                 stateNext = HOLD_LO;
               end
            end
            default: ;
         endcase
      end
   end

   // PWM: duty reloads only at period end so a brightness change never splits a period
   always_ff @(posedge clk) begin
      if (!rst) begin
         pwmCnt <= '0;
         duty   <= '0;
         nLED   <= ACTIVE_LOW;
      end else begin
         if (enable) begin
            pwmCnt <= pwmCnt + 1'b1;
            if (pwmCnt == MAX) duty <= brightness;
         end
         nLED <= ledOn ^ ACTIVE_LOW;
      end
   end
endmodule

// File: doc/led_breather.md
Name: led_breather

Overview:
- Downstream consumer of the Hertz clock divider's tick output. Turns a slow tick into a "breathing" LED: brightness ramps up, holds, ramps down, holds, and repeats.
- Brightness is rendered by a free-running PWM on the system clock and drives the board LED pin (active-low).
- Replaces the raw divided-clock-to-LED connection in top-level designs.

Parameters:
- PWM_BITS, 8: width of PWM counter, duty and brightness; MAX = 2^PWM_BITS-1.
- STEP, 1: brightness change per tick edge; range 1..MAX.
- HOLD_TICKS, 4: ticks spent at each extreme; 0 = no hold.
- ACTIVE_LOW, 1: 1 = LED on drives nLED low; 0 = LED on drives nLED high.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (rst=0 resets on next clk edge).
- enable  in  1  1 = run; 0 = freeze FSM/PWM and force LED off.
- tick  in  1  divider output, pulse or level; only rising edges are used.
- nLED  out  1  registered LED drive, polarity per ACTIVE_LOW.
- brightness  out  PWM_BITS  current target brightness.
- phase  out  2  FSM state: 0 RISE, 1 HOLD_HI, 2 FALL, 3 HOLD_LO.
- cycleDone  out  1  one-clk pulse when HOLD_LO exits to RISE.

Behaviour:
- Reset (rst=0 at clk edge), effective the next cycle regardless of enable or tick:
  - phase=RISE; brightness=0, duty=0, pwmCnt=0, holdCnt=0, tickD=0.
  - cycleDone=0; nLED = off level (1 if ACTIVE_LOW, else 0).
  - Reset mid-ramp or mid-hold discards all progress.
- Tick edge detect:
  - tickD <= tick every cycle, including while enable=0.
  - tickEdge = tick & ~tickD; a level held high counts once.
  - Edges while enable=0 are lost; an edge is not generated on re-enable unless tick rises again.
- FSM: acts only on tickEdge with enable=1. brightness/phase update on the edge where tickEdge=1 and are visible the next cycle.
  - RISE:
    - brightness = min(brightness+STEP, MAX), computed one bit wider and saturated.
    - If the result equals MAX: go to HOLD_HI with holdCnt=0, or straight to FALL if HOLD_TICKS=0.
  - HOLD_HI:
    - holdCnt++.
    - When holdCnt reaches HOLD_TICKS-1 on a tick: go to FALL, holdCnt=0.
  - FALL:
    - brightness = max(brightness-STEP, 0), no underflow.
    - On reaching 0: go to HOLD_LO, or straight to RISE if HOLD_TICKS=0.
  - HOLD_LO:
    - Same counting as HOLD_HI.
    - Exit to RISE; cycleDone=1 for exactly one cycle coincident with the phase change.
  - HOLD_TICKS=0 path: cycleDone pulses on the FALL->RISE transition instead.
- PWM:
  - pwmCnt increments every cycle while enable=1 and wraps MAX->0.
  - duty <= brightness only on cycles where pwmCnt==MAX, so there are no mid-period glitches.
  - ledOn = (pwmCnt < duty) & enable; nLED <= ACTIVE_LOW ? ~ledOn : ledOn (registered, 1-cycle latency).
  - duty=0 gives never on; duty=MAX gives on MAX of 2^PWM_BITS cycles.
- enable=0:
  - pwmCnt, duty, phase, brightness and holdCnt hold.
  - nLED goes to the off level on the next clk edge.
  - cycleDone=0.
  - Resumes from the held state when enable returns to 1.
- Simultaneous events:
  - tickEdge on a pwmCnt==MAX cycle: duty latches the OLD brightness; the new value applies one PWM period later.
  - rst=0 overrides everything.

Test Plan (PWM_BITS=4, MAX=15, STEP=5, HOLD_TICKS=2, ACTIVE_LOW=1 unless noted):
- Reset: hold rst=0 for 3 clks with tick toggling -> nLED=1, brightness=0, phase=0, cycleDone=0; release -> values unchanged until the first tick edge.
- Ramp: 3 single-cycle ticks -> brightness 5, 10, 15; phase=1 after the third. 2 more ticks -> phase=2. 3 ticks -> 10, 5, 0, phase=3. 2 ticks -> phase=0 with cycleDone high for exactly 1 clk.
- Saturation: STEP=6 -> RISE yields 6, 12, 15 (not 18); FALL yields 9, 3, 0 (no wrap).
- Level tick: tick held high for 40 clks -> brightness changes once (0->5).
- PWM duty: brightness=10 stable -> nLED low for 10 of every 16 clks once duty loads. A tick mid-period changes the low count only from the period after the next pwmCnt==15.
- Enable/reset mid-op: enable=0 in FALL at brightness=10 with 3 tick edges applied -> nLED=1, brightness stays 10; enable=1 -> next tick gives 5. Then rst=0 in HOLD_HI -> phase=0, brightness=0.
- HOLD_TICKS=0: full cycle is 3 up + 3 down ticks; phase never shows 1 or 3; cycleDone pulses on FALL->RISE.
